conv45_window_sequencer: RTL

//  Streams a raster-order image one pixel per handshake and builds the 5x5 sliding window for
//  the 45-degree symmetric Gabor convolution datapath. Drives pixel1..pixel25 as one flat bus.

---
 rtl/conv45_window_sequencer_pkg.sv | 20 ++
 rtl/conv45_window_sequencer_if.sv | 34 +++
 rtl/conv45_window_sequencer_line_buffer.sv | 34 +++
 rtl/conv45_window_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/conv45_window_sequencer_pkg.sv
// Purpose: shared types and constants for the 45-degree Gabor 5x5 window sequencer.
// Contents: pixel/window types, kernel geometry, sequencer state encoding.
package conv45_pkg;

  localparam int unsigned PIXEL_WIDTH = 9;
  localparam int unsigned KERNEL_SIZE = 5;
  localparam int unsigned WIN_PIXELS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned LB_ROWS     = KERNEL_SIZE - 1;

  typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [WIN_PIXELS-1:0]       win_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/conv45_window_sequencer_if.sv
// Purpose: pixel-in / window-out handshake bundle of the window sequencer.
// Signals: pix_valid/pix_ready/pix_data (raster pixel stream),
//          win_valid/win_ready/win_data/out_row/out_col (window stream).
// Modports: master = stream source/sink environment, slave = sequencer.
interface conv45_window_sequencer_if
  import conv45_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 516,
  parameter int unsigned IMG_HEIGHT = 516
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic             pix_valid;
  logic             pix_ready;
  pixel_t           pix_data;
  logic             win_valid;
  logic             win_ready;
  win_t             win_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, out_row, out_col
  );

  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, out_row, out_col
  );

endinterface

// File: rtl/conv45_window_sequencer_line_buffer.sv
// Purpose: four-row line buffer holding the previous rows of the raster, oldest row first.
// Ports: clk; we (pixel accepted); addr (current column); wdata (incoming pixel);
//        rd_col[0..3] (rows r-4..r-1 at addr, combinational, read before the write lands).
module conv45_line_buffer
  import conv45_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 516,
  parameter int unsigned ADDR_W    = $clog2(IMG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  pixel_t               wdata,
  output pixel_t [LB_ROWS-1:0] rd_col
);

  // One memory per row; a write moves each row's entry one row older at this column.
  for (genvar g = 0; g < LB_ROWS; g++) begin : g_row
    pixel_t mem [IMG_WIDTH];

    assign rd_col[g] = mem[addr];

    if (g == LB_ROWS - 1) begin : g_newest
      always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
      end
    end else begin : g_older
      always_ff @(posedge clk) begin
        if (we) mem[addr] <= rd_col[g+1];
      end
    end
  end

endmodule

// File: rtl/conv45_window_sequencer.sv
// Purpose: streams a raster image one pixel per handshake and emits the 5x5 sliding window
//          for every unpadded output position, with backpressure and frame start/end control.
// Ports: clk, rst (sync, active high); start (frame start pulse, honoured in IDLE);
//        bus (slave modport: pixel stream in, window stream out with out_row/out_col);
//        busy (not IDLE); done (one-cycle pulse after the final window handshake).
module conv45_window_sequencer
  import conv45_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 516,
  parameter int unsigned IMG_HEIGHT  = 516,
  parameter int unsigned KERNEL_SIZE = conv45_pkg::KERNEL_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  conv45_window_sequencer_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned K     = conv45_pkg::KERNEL_SIZE;

  if (KERNEL_SIZE != 5) begin : g_bad_kernel
    $error("conv45_window_sequencer: only KERNEL_SIZE 5 is supported");
  end

  seq_state_t       state;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  win_t             win_q;
  logic             win_valid_q;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;

  logic                 pix_ready_c;
  logic                 accept_c;
  logic                 col_last_c;
  logic                 row_last_c;
  logic                 qualify_c;
  pixel_t [LB_ROWS-1:0] lb_col;
  pixel_t [K-1:0]       new_col;

  // Accept only when the window register is free or being drained this cycle.
  assign pix_ready_c = ((state == FILL) || (state == STREAM)) && (!win_valid_q || bus.win_ready);
  assign accept_c    = bus.pix_valid && pix_ready_c;
  assign col_last_c  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last_c  = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign qualify_c   = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

  conv45_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .ADDR_W    (COL_W)
  ) u_line_buffer (
    .clk    (clk),
    .we     (accept_c),
    .addr   (col_q),
    .wdata  (bus.pix_data),
    .rd_col (lb_col)
  );

  // Incoming column, top (oldest row) to bottom (current pixel).
  always_comb begin
    for (int r = 0; r < K - 1; r++) new_col[r] = lb_col[r];
    new_col[K-1] = bus.pix_data;
  end

  // Sequencer FSM, counters, shift window and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept_c) begin
        // Shift left by one column; newest column enters on the right.
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win_q[r*K + c] <= win_q[r*K + c + 1];
          win_q[r*K + K - 1] <= new_col[r];
        end
        if (col_last_c) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      // A fresh window replaces a draining one in the same cycle.
      if (accept_c && qualify_c) begin
        win_valid_q <= 1'b1;
        out_row_q   <= row_q - ROW_W'(K - 1);
        out_col_q   <= col_q - COL_W'(K - 1);
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            busy  <= 1'b1;
            row_q <= '0;
            col_q <= '0;
          end
        end
        FILL: begin
          if (accept_c && (row_q == ROW_W'(K - 1)) && (col_q == COL_W'(K - 1))) begin
            state <= (row_last_c && col_last_c) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (accept_c && row_last_c && col_last_c) state <= FLUSH;
        end
        FLUSH: begin
          if (win_valid_q && bus.win_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

endmodule
